// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, ROM word addressing, 2-entry fetch queue toward decode.
// Latency: ROM word captured at the fetch edge, visible on out_* the following cycle.
// Backpressure: fetch stalls while the queue is full and decode is not popping; redirect overrides all.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 8,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]       imem_rd,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_instr,
    output logic                  out_misaligned
);

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;

    // Two-entry fetch queue; head/tail are single-bit pointers that wrap naturally.
    fetch_entry_t    q_mem [2];
    logic            q_head;
    logic            q_tail;
    logic [1:0]      q_count;

    logic            pop;
    logic            push;
    logic            redirect_misaligned;
    fetch_entry_t    q_wr_dat;
    fetch_entry_t    head_dat;

    // The ROM is word addressed; upper PC bits simply wrap around the 256-word array.
    assign imem_addr = pc[ADDR_WIDTH+1:2];

    assign out_valid = (q_count != 2'd0);

    // A redirect squashes any handshake in the same cycle so decode never consumes a stale entry.
    assign pop = out_valid && out_ready && !redirect_valid;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // A full queue can still accept a fetch when the head leaves in the same cycle.
    assign push = (state == RUN) && !redirect_valid && ((q_count != 2'd2) || pop);

    // Select what gets written into the queue: a fault marker on a bad target, else the fetched word.
    always_comb begin
        q_wr_dat = '0;
        if (redirect_misaligned) begin
            q_wr_dat.pc         = redirect_pc;
            q_wr_dat.instr      = NOP_INSTR;
            q_wr_dat.misaligned = 1'b1;
        end else begin
            q_wr_dat.pc         = pc;
            q_wr_dat.instr      = imem_rd;
            q_wr_dat.misaligned = 1'b0;
        end
    end

    // Present the head entry, forcing zeros whenever the queue is empty.
    always_comb begin
        head_dat = '0;
        if (out_valid) begin
            head_dat = q_mem[q_head];
        end
    end

    assign out_pc         = head_dat.pc;
    assign out_instr      = head_dat.instr;
    assign out_misaligned = head_dat.misaligned;

    // Queue storage and pointers; a redirect flushes and optionally seeds one fault entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_mem[0] <= '0;
            q_mem[1] <= '0;
            q_head   <= 1'b0;
            q_tail   <= 1'b0;
            q_count  <= 2'd0;
        end else if (redirect_valid) begin
            q_head <= 1'b0;
            if (redirect_misaligned) begin
                q_mem[0] <= q_wr_dat;
                q_tail   <= 1'b1;
                q_count  <= 2'd1;
            end else begin
                q_tail  <= 1'b0;
                q_count <= 2'd0;
            end
        end else begin
            if (push) begin
                q_mem[q_tail] <= q_wr_dat;
                q_tail        <= ~q_tail;
            end
            if (pop) begin
                q_head <= ~q_head;
            end
            if (push && !pop) begin
                q_count <= q_count + 2'd1;
            end else if (pop && !push) begin
                q_count <= q_count - 2'd1;
            end
        end
    end

    // Fetch FSM and PC: redirects take priority, otherwise advance by one word per accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= RUN;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= redirect_misaligned ? HALT : RUN;
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed scenarios.
// Latency: model stepped and compared 1 time unit after each rising edge.
// Backpressure: out_ready toggled by the directed stimulus.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misaligned;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // ROM contents: word k holds 0x1000_0000 + k.
    assign imem_rd = 32'h1000_0000 + {24'h0, imem_addr};

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misaligned (out_misaligned)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc  = 32'h0;
    bit          mhalt = 1'b0;

    function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
        return 32'h1000_0000 + {24'h0, byte_addr[9:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int n;
        bit popped;
        ent_t e;
        n = mq.size();
        if (redirect_valid) begin
            mq.delete();
            mpc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                e.pc = redirect_pc; e.instr = 32'h13; e.mis = 1'b1;
                mq.push_back(e);
                mhalt = 1'b1;
            end else begin
                mhalt = 1'b0;
            end
        end else begin
            popped = (n > 0) && out_ready;
            if (popped) void'(mq.pop_front());
            if (!mhalt && (n < 2 || popped)) begin
                e.pc = mpc; e.instr = rom_word(mpc); e.mis = 1'b0;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // Model update and comparison, just after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                mpc   = 32'h0;
                mhalt = 1'b0;
            end else begin
                model_step();
            end
            if (mq.size() == 0) begin
                chk("m_valid", out_valid, 0);
                chk("m_pc", out_pc, 0);
                chk("m_instr", out_instr, 0);
                chk("m_mis", out_misaligned, 0);
            end else begin
                chk("m_valid", out_valid, 1);
                chk("m_pc", out_pc, mq[0].pc);
                chk("m_instr", out_instr, mq[0].instr);
                chk("m_mis", out_misaligned, mq[0].mis);
            end
            chk("m_imem_addr", imem_addr, {24'h0, mpc[9:2]});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_mis", out_misaligned, 0);
        chk("rst_addr", imem_addr, 0);

        // Streaming with decode always ready.
        rst_n = 1'b1;
        #1 chk("t1_valid_at_release", out_valid, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_i0", out_instr, 32'h1000_0000);
        @(negedge clk);
        chk("t1_pc1", out_pc, 32'h4);
        chk("t1_i1", out_instr, 32'h1000_0001);
        @(negedge clk);
        chk("t1_pc2", out_pc, 32'h8);
        chk("t1_i2", out_instr, 32'h1000_0002);

        // Decode stalled after reset: queue fills, PC holds at 8.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_hold_pc", out_pc, 32'h0);
        chk("t2_addr", imem_addr, 8'h02);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_pc4", out_pc, 32'h4);
        @(negedge clk);
        chk("t2_pc8", out_pc, 32'h8);
        chk("t2_i8", out_instr, 32'h1000_0002);
        @(negedge clk);
        chk("t2_pc12", out_pc, 32'hC);

        // Aligned redirect while the queue is full.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t3_flush_valid", out_valid, 0);
        @(negedge clk);
        chk("t3_valid", out_valid, 1);
        chk("t3_pc", out_pc, 32'h40);
        chk("t3_instr", out_instr, 32'h1000_0010);
        @(negedge clk);
        chk("t3_stable_pc", out_pc, 32'h40);

        // Misaligned redirect: one fault entry, then fetch suspended.
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t4_valid", out_valid, 1);
        chk("t4_mis", out_misaligned, 1);
        chk("t4_pc", out_pc, 32'h42);
        chk("t4_instr", out_instr, 32'h13);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_halt_idle", out_valid, 0);
        end
        chk("t4_halt_addr", imem_addr, 8'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t4_resume_gap", out_valid, 0);
        @(negedge clk);
        chk("t4_resume_pc", out_pc, 32'h80);
        chk("t4_resume_instr", out_instr, 32'h1000_0020);
        chk("t4_resume_mis", out_misaligned, 0);

        // Memory wrap: PC keeps counting, word address truncates.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t5_addr_ff", imem_addr, 8'hFF);
        @(negedge clk);
        chk("t5_pc3fc", out_pc, 32'h3FC);
        chk("t5_i3fc", out_instr, 32'h1000_00FF);
        chk("t5_addr_00", imem_addr, 8'h00);
        @(negedge clk);
        chk("t5_pc400", out_pc, 32'h400);
        chk("t5_i400", out_instr, 32'h1000_0000);
        chk("t5_addr_01", imem_addr, 8'h01);
        @(negedge clk);
        chk("t5_pc404", out_pc, 32'h404);
        chk("t5_i404", out_instr, 32'h1000_0001);

        // Asynchronous reset with a full queue.
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_full_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_pc", out_pc, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_restart_valid", out_valid, 1);
        chk("t6_restart_pc", out_pc, 32'h0);
        chk("t6_restart_instr", out_instr, 32'h1000_0000);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 256-word instruction memory.
- Holds the program counter and drives the word address into the asynchronous-read instruction ROM.
- Captures the returned instruction word together with its PC into a 2-entry fetch queue, and presents it to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump/trap) and misaligned redirect targets.

Parameters:
- XLEN, 32, instruction and PC width.
- ADDR_WIDTH, 8, instruction-memory word-address width (256 words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_WIDTH  word address to instruction memory; equals pc[ADDR_WIDTH+1:2].
- imem_rd  input  XLEN  instruction word from memory, combinationally valid in the same cycle as imem_addr.
- redirect_valid  input  1  control-flow change request.
- redirect_pc  input  XLEN  redirect target byte address.
- out_valid  output  1  head queue entry valid.
- out_ready  input  1  decode accepts head entry.
- out_pc  output  XLEN  PC of head entry.
- out_instr  output  XLEN  instruction of head entry.
- out_misaligned  output  1  head entry is a misaligned-target fault; out_instr is 32'h0000_0013 (NOP) for such entries.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC.
  - Queue empty; count = 0.
  - FSM = RUN.
  - out_valid = 0, out_pc = 0, out_instr = 0, out_misaligned = 0.
- Queue:
  - 2 entries of {pc, instr, misaligned}, with head/tail pointers and a count of 0..2.
  - out_valid = (count != 0). out_* show the head entry and are 0 when empty.
  - pop = out_valid && out_ready.
- FSM states:
  - RUN: fetching.
  - HALT: a misaligned target was enqueued; fetching is suspended.
- Fetch (RUN, no redirect): push = (count < 2) || pop.
  - On push: enqueue {pc, imem_rd, 0} and set pc <= pc + 4 (XLEN wrap, no saturation).
  - Otherwise pc holds.
  - Throughput is one instruction per cycle when decode is always ready.
- Simultaneous push and pop with count == 2: count stays 2, both pointers advance.
- Memory wrap: imem_addr truncates pc. PC 0x400 reads word 0. out_pc reports the full untruncated pc.
- Redirect (highest priority, overrides pop, push and stall):
  - Queue is flushed; count = 0 next cycle.
  - Any pop this cycle is discarded; decode must not consume it.
  - If redirect_pc[1:0] == 0: pc <= redirect_pc, FSM -> RUN, no enqueue this cycle. The first target instruction appears on out_* in the following cycle, so redirect-to-valid latency is 1 cycle.
  - If redirect_pc[1:0] != 0: enqueue a single entry {redirect_pc, 32'h13, 1}, pc <= redirect_pc, FSM -> HALT. out_valid rises next cycle with out_misaligned = 1.
- HALT:
  - No pushes; pops are still honoured.
  - Leaves HALT only on a redirect (aligned -> RUN, misaligned -> HALT again with a new fault entry).
- Redirect while the queue is full or while in HALT behaves identically to the rules above.
- Reset asserted mid-operation: immediate return to reset state; in-flight entries are discarded.
- Out_* registers/queue contents are stable while out_valid && !out_ready.

Test Plan:
- Reset, out_ready = 1, ROM word k = 0x1000_0000 + k → out_valid rises 1 cycle after reset release; out_pc = 0, 4, 8 with out_instr 0x1000_0000, 0x1000_0001, 0x1000_0002 on consecutive cycles.
- out_ready = 0 for 5 cycles after reset → count saturates at 2, pc holds at 8, out_pc holds 0. Then out_ready = 1 → 0, 4, 8 delivered back-to-back with no gap or duplication.
- Full queue, redirect_valid with redirect_pc = 0x40 → next cycle out_valid = 0. Following cycle out_pc = 0x40, out_instr = ROM[16]. No stale entries (0, 4) ever appear.
- Redirect to 0x42 → next cycle out_valid = 1, out_misaligned = 1, out_pc = 0x42, out_instr = 0x13. After the pop, out_valid stays 0 for 10 cycles. Then redirect to 0x80 resumes with out_pc = 0x80.
- Redirect to 0x3FC, out_ready = 1 → out_pc sequence 0x3FC, 0x400, 0x404 with imem_addr 0xFF, 0x00, 0x01.
- Assert rst_n low mid-stream with count = 2 → out_valid = 0 immediately (async). After release, out_pc restarts at RESET_PC.
